// File: rtl/rfifo_cmd_seq.sv
// Read-side command sequencer: drains header/data packets from the async command FIFO
// and issues them as single-beat request/grant bus transfers.
module rfifo_cmd_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  rclk,
    input  logic                  r_rst,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  rinc,
    output logic                  bus_req,
    output logic                  bus_wen,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic                  bus_gnt,
    input  logic                  abort,
    output logic                  busy,
    output logic                  err,
    input  logic                  err_clr
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RD    = 2'd1,
        S_WR    = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    localparam logic [1:0] OP_RD  = 2'b00;
    localparam logic [1:0] OP_WRI = 2'b01;
    localparam logic [1:0] OP_WRF = 2'b10;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [23:0] addr_q, addr_d;
    logic [6:0]  beats_q, beats_d;
    logic        err_q, err_d;

    logic [1:0]  hdr_op_s;
    logic [5:0]  hdr_len_s;
    logic [23:0] hdr_addr_s;
    logic        rinc_s;
    logic        req_s;
    logic        accept_s;

    assign hdr_op_s   = rdata[31:30];
    assign hdr_len_s  = rdata[29:24];
    assign hdr_addr_s = rdata[23:0];

    // Reset must never pop the FIFO or present a request, even from a live WR state.
    assign rinc     = rinc_s & ~r_rst;
    assign bus_req  = req_s & ~r_rst;
    assign accept_s = req_s & bus_gnt;
    assign busy     = (state_q != S_IDLE);
    assign err      = err_q;

    // State and datapath registers.
    always_ff @(posedge rclk) begin
        if (r_rst) begin
            state_q <= S_IDLE;
            op_q    <= 2'b00;
            addr_q  <= 24'd0;
            beats_q <= 7'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            beats_q <= beats_d;
            err_q   <= err_d;
        end
    end

    // Next-state and counter update.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        beats_d = beats_q;
        if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    op_d    = hdr_op_s;
                    beats_d = {1'b0, hdr_len_s} + 7'd1;
                    addr_d  = hdr_addr_s;
                    case (hdr_op_s)
                        OP_RD:          state_d = S_RD;
                        OP_WRI, OP_WRF: state_d = S_WR;
                        default: begin
                            state_d = S_IDLE;
                            err_d   = 1'b1;
                        end
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD: begin
                if (bus_gnt) begin
                    beats_d = beats_q - 7'd1;
                    addr_d  = addr_q + 24'd1;
                end else begin
                    beats_d = beats_q;
                end
                if ((bus_gnt && (beats_q == 7'd1)) || abort) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RD;
                end
            end
            S_WR: begin
                if (accept_s) begin
                    beats_d = beats_q - 7'd1;
                    if (op_q == OP_WRI) begin
                        addr_d = addr_q + 24'd1;
                    end else begin
                        addr_d = addr_q;
                    end
                end else begin
                    beats_d = beats_q;
                end
                // A grant in the abort cycle still counts; flush only what is left.
                if (beats_d == 7'd0) begin
                    state_d = S_IDLE;
                end else if (abort) begin
                    state_d = S_FLUSH;
                end else begin
                    state_d = S_WR;
                end
            end
            S_FLUSH: begin
                if (rinc_s) begin
                    beats_d = beats_q - 7'd1;
                    if (beats_q == 7'd1) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_FLUSH;
                    end
                end else begin
                    state_d = S_FLUSH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bus and FIFO handshake outputs.
    always_comb begin
        rinc_s    = 1'b0;
        req_s     = 1'b0;
        bus_wen   = 1'b0;
        bus_wdata = '0;
        case (state_q)
            S_IDLE:  rinc_s = !empty;
            S_RD:    req_s = 1'b1;
            S_WR: begin
                req_s     = !empty;
                bus_wen   = 1'b1;
                bus_wdata = rdata;
                rinc_s    = !empty & bus_gnt;
            end
            S_FLUSH: rinc_s = !empty;
            default: rinc_s = 1'b0;
        endcase
    end

    // Word address widened to a byte address with zero upper bits.
    always_comb begin
        bus_addr       = '0;
        bus_addr[25:0] = {addr_q, 2'b00};
    end

endmodule

// File: tb/tb_rfifo_cmd_seq.sv
// Bench for rfifo_cmd_seq: FIFO model, transaction scoreboard, vector table and corner sequences.
module tb_rfifo_cmd_seq;

    logic        rclk = 1'b0;
    logic        r_rst, empty, rinc, bus_req, bus_wen, bus_gnt, abort, busy, err, err_clr;
    logic [31:0] rdata, bus_addr, bus_wdata;

    always #5 rclk = ~rclk;

    rfifo_cmd_seq #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .rclk(rclk), .r_rst(r_rst), .empty(empty), .rdata(rdata), .rinc(rinc),
        .bus_req(bus_req), .bus_wen(bus_wen), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_gnt(bus_gnt), .abort(abort), .busy(busy), .err(err), .err_clr(err_clr)
    );

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    typedef struct {
        logic [31:0] hdr;
        int          ndata;
        logic [31:0] dbase;
        logic        wen;
        logic [31:0] addr0;
        logic        inc;
        int          beats;
    } vec_t;

    logic [31:0] fifo_q[$];
    txn_t        exp_q[$];
    vec_t        vecs[5];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, {31'd0, act}, {31'd0, exp});
    endtask

    task automatic update_view();
        empty = (fifo_q.size() == 0);
        rdata = empty ? 32'hDEAD_BEEF : fifo_q[0];
    endtask

    task automatic push_word(input logic [31:0] w);
        fifo_q.push_back(w);
        update_view();
    endtask

    task automatic expect_txn(input logic wen, input logic [31:0] addr, input logic [31:0] wdata);
        txn_t t;
        t.wen   = wen;
        t.addr  = addr;
        t.wdata = wdata;
        exp_q.push_back(t);
    endtask

    // One clock: score any handshake, then pop the FIFO model if the DUT popped.
    task automatic step();
        txn_t        t;
        logic        popped;
        logic [31:0] dummy;
        #1;
        check1("rinc_while_empty", rinc & empty, 1'b0);
        if (bus_req && bus_gnt) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_beat: got beat at 0x%0h, expected none", bus_addr);
            end else begin
                t = exp_q.pop_front();
                check1("beat_wen", bus_wen, t.wen);
                check("beat_addr", bus_addr, t.addr);
                check("beat_wdata", bus_wdata, t.wdata);
            end
        end
        popped = rinc;
        @(posedge rclk);
        #1;
        if (popped && (fifo_q.size() > 0)) begin
            dummy = fifo_q.pop_front();
        end
        update_view();
        @(negedge rclk);
    endtask

    task automatic run_idle(input int max, output int cycles);
        cycles = 0;
        while (!(!busy && (fifo_q.size() == 0) && (exp_q.size() == 0)) && (cycles < max)) begin
            step();
            cycles++;
        end
        if (cycles >= max) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: got %0d cycles without draining, expected fewer than %0d", cycles, max);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation time limit, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{hdr: 32'h0200_0010, ndata: 0, dbase: 32'h0, wen: 1'b0, addr0: 32'h40, inc: 1'b1, beats: 3};
        vecs[1] = '{hdr: 32'h4100_0004, ndata: 2, dbase: 32'hA, wen: 1'b1, addr0: 32'h10, inc: 1'b1, beats: 2};
        vecs[2] = '{hdr: 32'h8200_0008, ndata: 3, dbase: 32'h100, wen: 1'b1, addr0: 32'h20, inc: 1'b0, beats: 3};
        vecs[3] = '{hdr: 32'h0000_0FFF, ndata: 0, dbase: 32'h0, wen: 1'b0, addr0: 32'h3FFC, inc: 1'b1, beats: 1};
        vecs[4] = '{hdr: 32'h7F00_0000, ndata: 64, dbase: 32'h1000, wen: 1'b1, addr0: 32'h0, inc: 1'b1, beats: 64};

        r_rst = 1'b1; bus_gnt = 1'b0; abort = 1'b0; err_clr = 1'b0;
        update_view();
        @(negedge rclk);
        step();
        step();
        r_rst = 1'b0;
        #1;
        check1("rst_rinc", rinc, 1'b0);
        check1("rst_req", bus_req, 1'b0);
        check1("rst_wen", bus_wen, 1'b0);
        check("rst_addr", bus_addr, 32'h0);
        check("rst_wdata", bus_wdata, 32'h0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_err", err, 1'b0);

        // Vector table, grant held high.
        bus_gnt = 1'b1;
        for (int v = 0; v < 5; v++) begin
            push_word(vecs[v].hdr);
            for (int i = 0; i < vecs[v].ndata; i++) push_word(vecs[v].dbase + 32'(i));
            for (int i = 0; i < vecs[v].beats; i++) begin
                expect_txn(vecs[v].wen,
                           (vecs[v].addr0 + (vecs[v].inc ? 32'(4 * i) : 32'd0)) & 32'h03FF_FFFF,
                           vecs[v].wen ? vecs[v].dbase + 32'(i) : 32'd0);
            end
            run_idle(200, cyc);
            check("vec_cycles", 32'(cyc), 32'(vecs[v].beats + 1));
            check1("vec_busy_low", busy, 1'b0);
        end

        // Write incrementing with grant toggling 1,0,1.
        push_word(32'h4100_0004); push_word(32'hA); push_word(32'hB);
        expect_txn(1'b1, 32'h10, 32'hA);
        expect_txn(1'b1, 32'h14, 32'hB);
        bus_gnt = 1'b0;
        step();
        bus_gnt = 1'b1; #1 check1("tog_rinc_g1", rinc, 1'b1);
        step();
        bus_gnt = 1'b0; #1 check1("tog_rinc_g0", rinc, 1'b0);
        check1("tog_req_held", bus_req, 1'b1);
        check("tog_addr_held", bus_addr, 32'h14);
        step();
        bus_gnt = 1'b1; #1 check1("tog_rinc_g2", rinc, 1'b1);
        step();
        check1("tog_idle", busy, 1'b0);
        check("tog_sb_empty", 32'(exp_q.size()), 32'd0);

        // Fixed-address write with starvation.
        push_word(32'h8200_0008); push_word(32'h200);
        expect_txn(1'b1, 32'h20, 32'h200);
        expect_txn(1'b1, 32'h20, 32'h201);
        expect_txn(1'b1, 32'h20, 32'h202);
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            #1 check1("starve_req", bus_req, 1'b0);
            check1("starve_busy", busy, 1'b1);
            step();
        end
        push_word(32'h201); push_word(32'h202);
        run_idle(50, cyc);

        // Abort in the cycle the 2nd beat is granted.
        push_word(32'h4300_0040);
        for (int i = 0; i < 4; i++) push_word(32'hD0 + 32'(i));
        push_word(32'h0000_0020);
        expect_txn(1'b1, 32'h100, 32'hD0);
        expect_txn(1'b1, 32'h104, 32'hD1);
        expect_txn(1'b0, 32'h80, 32'h0);
        step();
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1 check1("flush_req", bus_req, 1'b0);
            check1("flush_rinc", rinc, 1'b1);
            check1("flush_busy", busy, 1'b1);
            step();
        end
        run_idle(50, cyc);

        // Reserved op, err_clr collision, wrap-around read.
        check1("err_before", err, 1'b0);
        push_word(32'hC000_0000);
        step();
        check1("rsv_err", err, 1'b1);
        check1("rsv_busy", busy, 1'b0);
        check1("rsv_req", bus_req, 1'b0);
        check("rsv_popped", 32'(fifo_q.size()), 32'd0);
        err_clr = 1'b1;
        push_word(32'hC000_0000);
        step();
        err_clr = 1'b0;
        check1("err_set_wins", err, 1'b1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check1("err_cleared", err, 1'b0);
        push_word(32'h01FF_FFFF);
        expect_txn(1'b0, 32'h03FF_FFFC, 32'h0);
        expect_txn(1'b0, 32'h0, 32'h0);
        run_idle(50, cyc);

        // Reset after the 1st of 4 write beats.
        push_word(32'h4300_0000);
        push_word(32'hAAAA_0001); push_word(32'hC000_0002);
        push_word(32'h0000_0003); push_word(32'h0000_0004);
        expect_txn(1'b1, 32'h0, 32'hAAAA_0001);
        step();
        step();
        r_rst = 1'b1;
        #1 check1("rst_no_pop", rinc, 1'b0);
        step();
        r_rst = 1'b0;
        #1 check1("mid_rst_req", bus_req, 1'b0);
        check1("mid_rst_wen", bus_wen, 1'b0);
        check("mid_rst_addr", bus_addr, 32'h0);
        check("mid_rst_wdata", bus_wdata, 32'h0);
        check1("mid_rst_busy", busy, 1'b0);
        check1("mid_rst_err", err, 1'b0);
        check("mid_rst_fifo", 32'(fifo_q.size()), 32'd3);
        step();
        check1("mid_rst_hdr_err", err, 1'b1);
        expect_txn(1'b0, 32'hC, 32'h0);
        expect_txn(1'b0, 32'h10, 32'h0);
        run_idle(50, cyc);

        check("final_sb_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rfifo_cmd_seq.md
# rfifo_cmd_seq

Read-side command sequencer for the JTAG async command FIFO. It sits in the read clock domain behind the FIFO read pointer/empty logic and drains the FIFO one packet at a time. Each packet is a header word followed by optional data words, and the sequencer turns each packet into single-beat requests on a simple request/grant bus master port. It owns the FIFO pop signal: no other block asserts `rinc` on this FIFO.

## Interface
Parameters:
- DATA_WIDTH, 32: FIFO word width and bus write-data width. Minimum 32.
- ADDR_WIDTH, 32: bus byte-address width. Minimum 26.

Ports:
- rclk  in  1  read-domain clock; all logic on its rising edge.
- r_rst  in  1  synchronous, active-high reset.
- empty  in  1  FIFO empty flag.
- rdata  in  DATA_WIDTH  FIFO word at the read address. Valid whenever `empty` is 0.
- rinc  out  1  FIFO pop, one word per cycle.
- bus_req  out  1  request valid.
- bus_wen  out  1  1 = write, 0 = read.
- bus_addr  out  ADDR_WIDTH  byte address, equal to {zero-extend(cur_addr), 2'b00}.
- bus_wdata  out  DATA_WIDTH  write data.
- bus_gnt  in  1  the request is accepted in any cycle where `bus_req` and `bus_gnt` are both 1.
- abort  in  1  abort the current packet.
- busy  out  1  state is not IDLE.
- err  out  1  sticky: a reserved opcode was seen.
- err_clr  in  1  clears `err`.

## Operation
Header fields:
- op = rdata[31:30]: 00 read incrementing, 01 write incrementing, 10 write fixed-address, 11 reserved.
- len = rdata[29:24]; beats = len+1 (range 1..64).
- waddr = rdata[23:0], a word address.

Registers: state, op_r, cur_addr[23:0], beats_left[6:0], err.

States:
- IDLE: `rinc` = !empty. When !empty, latch op, set beats_left = len+1 and cur_addr = waddr.
  - Next state: op 00 → RD; op 01/10 → WR; op 11 → stay IDLE and set err.
- RD:
  - Outputs: `bus_req` = 1, `bus_wen` = 0, `rinc` = 0.
  - On gnt: beats_left−1 and cur_addr+1. If beats_left was 1, go to IDLE.
- WR:
  - Outputs: `bus_req` = !empty, `bus_wen` = 1, `bus_wdata` = rdata, `rinc` = bus_req & bus_gnt.
  - On gnt: beats_left−1; cur_addr+1 only for op 01. If beats_left was 1, go to IDLE.
- FLUSH (entered only from WR on abort):
  - Outputs: `rinc` = !empty, `bus_req` = 0.
  - Each pop: beats_left−1. Go to IDLE after the pop where beats_left was 1.

Abort rules:
- abort in RD: go to IDLE after that cycle.
- abort in WR: go to FLUSH, with beats_left reflecting that cycle's gnt. If that leaves 0, go to IDLE instead.
- abort in IDLE or FLUSH: ignored.
- A beat granted in the same cycle as abort completes normally.

Arithmetic and boundaries:
- cur_addr is 24 bits and wraps 0xFFFFFF → 0x000000. bus_addr upper bits stay zero.
- `rinc` is never 1 while `empty` = 1.
- In WR with `empty` = 1: `bus_req` drops to 0, and the sequencer waits indefinitely with no timeout.

Error flag:
- err is set on reserved op and cleared by err_clr. If both happen in the same cycle, set wins.

Reset:
- Reset mid-packet abandons the packet: state, counters and err return to reset values.
- Words still in the FIFO are not popped by reset. The next header is read from whatever word is at the FIFO head.

## Timing
- Reset values: `rinc` 0, `bus_req` 0, `bus_wen` 0, `bus_addr` 0, `bus_wdata` 0 (driven from rdata only in WR, otherwise 0), `busy` 0, `err` 0, state IDLE.
- Header popped in cycle T → first `bus_req` in T+1.
- With `bus_gnt` held high and data available, one beat per cycle.
- Last beat granted in T → IDLE in T+1, which pops the next header if present → next `bus_req` in T+2. This is a one-cycle bubble between packets.
- `bus_req`, `bus_addr` and `bus_wen` hold stable until granted, except `bus_req` in WR, which follows `empty`.
- All outputs except the WR-state `bus_req`, `bus_wdata` and `rinc` are pure functions of registered state.

## Test plan
- Read packet: header 0x0200_0010 (op 00, len 2, waddr 0x10), `bus_gnt` = 1 → 3 read reqs at addrs 0x40, 0x44, 0x48 in consecutive cycles; `rinc` pulses once; `busy` falls after the 3rd beat.
- Write incrementing: header 0x4100_0004 then data 0xA, 0xB, with `bus_gnt` toggling 1,0,1 → writes 0xA@0x10 then 0xB@0x14. `rinc` is asserted only in the granted cycles.
- Write fixed-address plus starvation: header 0x8200_0008 with only 1 data word present → one write @0x20, then `bus_req` = 0 while empty. Pushing 2 more words → two more writes, both @0x20.
- Abort: write packet with len 3; abort in the cycle the 2nd beat is granted → 2 beats written, 2 remaining data words popped with `bus_req` = 0, back to IDLE; the following header then executes normally.
- Reserved op and wrap-around:
  - Header 0xC000_0000 → popped, `err` = 1, no bus request.
  - `err_clr` and a second reserved header in the same cycle → `err` stays 1.
  - Read with waddr 0xFFFFFF, len 1 → addrs 0x3FFFFFC then 0x0.
- Reset mid-WR: assert `r_rst` for 1 cycle after the 1st of 4 beats → all outputs 0 next cycle; the remaining data words are parsed as headers, the first being data word 2 (0xC… ⇒ `err` = 1).
